logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit that applies one of eight gate operations across a WIDTH-bit operand pair. It has a valid/ready handshake on both the input and the output, and two register stages. Stage 1 computes the bitwise result. Stage 2 registers it together with status flags. It is the streaming successor to the single-bit gate primitives and feeds datapath blocks that need backpressure-safe logic ops.

---
 rtl/logic_unit_pkg.sv | 48 ++++
 rtl/logic_op_core.sv | 19 +
 rtl/logic_unit_pipe.sv | 163 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcode encodings and the bitwise op function
// shared by the logic unit pipeline and its combinational core.
package logic_unit_pkg;

    localparam int OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_AND    = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_OR     = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_NOT    = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_XOR    = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_XNOR   = 3'd6;
    localparam logic [OP_WIDTH-1:0] OP_PASS_A = 3'd7;

    // Widest operand the shared function handles; callers
    // zero-extend into it and truncate the result back.
    localparam int MAX_W = 256;

    // Bitwise op on MAX_W-wide operands; bits at or above w
    // are forced to zero so inverting ops stay clean.
    function automatic logic [MAX_W-1:0] logic_op(
        input logic [OP_WIDTH-1:0] op,
        input logic [MAX_W-1:0]    a,
        input logic [MAX_W-1:0]    b,
        input int                  w
    );
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        unique case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_NOT:    r = ~a;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XOR:    r = a ^ b;
            OP_XNOR:   r = ~(a ^ b);
            OP_PASS_A: r = a;
            default:   r = a;
        endcase
        return r & m;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: purely combinational WIDTH-bit opcode mux
// feeding stage 1 of logic_unit_pipe.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    y
);

    // Widen, apply the shared op function, narrow back
    always_comb begin
        y = WIDTH'(logic_op(op, MAX_W'(a), MAX_W'(b), WIDTH));
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit.
// Optional LOGIC_POPCOUNT_EN adds a registered out_popcount.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = OP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
`ifdef LOGIC_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcount
`endif
);

    logic [WIDTH-1:0] core_y;

    logic             s2_load;
    logic             s1_load;
    logic             in_fire;

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;

    logic             s2_valid_q, s2_valid_d;
    logic [OP_W-1:0]  s2_op_q, s2_op_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_ones_q, s2_ones_d;
    logic             s2_par_q, s2_par_d;

`ifdef LOGIC_POPCOUNT_EN
    localparam int PC_W = $clog2(WIDTH+1);
    logic [PC_W-1:0] s2_pc_q, s2_pc_d;
    logic [PC_W-1:0] s1_pc;
`endif

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (in_op),
        .a  (in_a),
        .b  (in_b),
        .y  (core_y)
    );

    // Handshake: a stage loads when empty or when the one after it moves
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = !rst && s1_load;
        in_fire  = in_valid && in_ready;
    end

    // Stage 1 next state: capture the op result on input transfer
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_y_d     = s1_y_q;
        if (s1_load) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            s1_op_d = in_op;
            s1_y_d  = core_y;
        end
    end

`ifdef LOGIC_POPCOUNT_EN
    // Popcount of the stage-1 result, registered with the flags
    always_comb begin
        s1_pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_pc = s1_pc + PC_W'(s1_y_q[i]);
        end
    end
`endif

    // Stage 2 next state: move stage 1 forward and derive flags
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_op_d    = s2_op_q;
        s2_y_d     = s2_y_q;
        s2_zero_d  = s2_zero_q;
        s2_ones_d  = s2_ones_q;
        s2_par_d   = s2_par_q;
`ifdef LOGIC_POPCOUNT_EN
        s2_pc_d    = s2_pc_q;
`endif
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load && s1_valid_q) begin
            s2_op_d   = s1_op_q;
            s2_y_d    = s1_y_q;
            s2_zero_d = (s1_y_q == '0);
            s2_ones_d = &s1_y_q;
            s2_par_d  = ^s1_y_q;
`ifdef LOGIC_POPCOUNT_EN
            s2_pc_d   = s1_pc;
`endif
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_y_q     <= '0;
            s2_zero_q  <= 1'b1;
            s2_ones_q  <= 1'b0;
            s2_par_q   <= 1'b0;
`ifdef LOGIC_POPCOUNT_EN
            s2_pc_q    <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q    <= s2_op_d;
            s2_y_q     <= s2_y_d;
            s2_zero_q  <= s2_zero_d;
            s2_ones_q  <= s2_ones_d;
            s2_par_q   <= s2_par_d;
`ifdef LOGIC_POPCOUNT_EN
            s2_pc_q    <= s2_pc_d;
`endif
        end
    end

    // Outputs come straight from stage-2 registers
    always_comb begin
        out_valid  = s2_valid_q;
        out_y      = s2_y_q;
        out_op     = s2_op_q;
        out_zero   = s2_zero_q;
        out_ones   = s2_ones_q;
        out_parity = s2_par_q;
`ifdef LOGIC_POPCOUNT_EN
        out_popcount = s2_pc_q;
`endif
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe
// (WIDTH=8 main instance plus a WIDTH=1 instance).
module tb_logic_unit_pipe;

    localparam int W   = 8;
    localparam int PCW = $clog2(W+1);

    typedef struct {
        logic [W-1:0] y;
        logic [2:0]   op;
        int           acc;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_y;
    logic [2:0]   out_op;
    logic         out_zero, out_ones, out_parity;
    logic [PCW-1:0] out_pc;

    logic       v1_in_valid = 1'b0;
    logic       v1_in_ready;
    logic [2:0] v1_in_op = '0;
    logic [0:0] v1_in_a = '0;
    logic [0:0] v1_in_b = '0;
    logic       v1_out_valid;
    logic [0:0] v1_out_y;
    logic [2:0] v1_out_op;
    logic       v1_zero, v1_ones, v1_par;
    logic [0:0] v1_pc;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q[$];
    bit rand_bp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
`ifdef LOGIC_POPCOUNT_EN
        .out_popcount (out_pc),
`endif
        .out_parity (out_parity)
    );

    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v1_in_valid),
        .in_ready   (v1_in_ready),
        .in_op      (v1_in_op),
        .in_a       (v1_in_a),
        .in_b       (v1_in_b),
        .out_valid  (v1_out_valid),
        .out_ready  (1'b1),
        .out_y      (v1_out_y),
        .out_op     (v1_out_op),
        .out_zero   (v1_zero),
        .out_ones   (v1_ones),
`ifdef LOGIC_POPCOUNT_EN
        .out_popcount (v1_pc),
`endif
        .out_parity (v1_par)
    );

`ifndef LOGIC_POPCOUNT_EN
    assign out_pc = '0;
    assign v1_pc  = '0;
`endif

    // Reference: each op is a 2-input truth table indexed by {a_bit,b_bit}
    function automatic logic [W-1:0] ref_y(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0011;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b0110;
            3'd6: tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic int ones_of(input logic [W-1:0] y);
        int n = 0;
        for (int i = 0; i < W; i++) if (y[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and
    // checks that a stalled output stays frozen
    logic           hold_p = 0;
    logic [W-1:0]   y_p;
    logic [2:0]     op_p;
    logic           z_p, o_p, p_p;
    logic [PCW-1:0] pc_p;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_p = 0;
        end else begin
            if (hold_p) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", out_y, y_p);
                chk("hold_op", out_op, op_p);
                chk("hold_flags", {out_zero, out_ones, out_parity},
                    {z_p, o_p, p_p});
`ifdef LOGIC_POPCOUNT_EN
                chk("hold_popcount", out_pc, pc_p);
`endif
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got y=%0h expected none",
                             out_y);
                end else begin
                    e = q.pop_front();
                    chk("y", out_y, e.y);
                    chk("op", out_op, e.op);
                    chk("zero", out_zero, e.y == '0);
                    chk("ones", out_ones, ones_of(e.y) == W);
                    chk("parity", out_parity, ones_of(e.y) % 2);
`ifdef LOGIC_POPCOUNT_EN
                    chk("popcount", out_pc, ones_of(e.y));
`endif
                    if (e.lat) chk("latency", cyc - e.acc, 2);
                end
            end
            hold_p = out_valid && !out_ready;
            y_p  = out_y;
            op_p = out_op;
            z_p  = out_zero;
            o_p  = out_ones;
            p_p  = out_parity;
            pc_p = out_pc;
        end
    end

    // Random backpressure while enabled
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer one beat; call at posedge+1, returns at posedge+1
    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ey,
                        input bit lat);
        exp_t e;
        int   n = 0;
        in_valid = 1;
        in_op = op;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                in_valid = 0;
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
        end
        e.y = ey;
        e.op = op;
        e.acc = cyc;
        e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sweep_y [8];
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    bit           seen;

    initial begin
        sweep_y = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'hA5};

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_flags", {out_zero, out_ones, out_parity}, 3'b100);
        chk("rst_popcount", out_pc, 0);
        chk("rst_in_ready_after", in_ready, 1);
        @(posedge clk);
        #1;

        // opcode sweep and flag beats back-to-back
        for (int i = 0; i < 8; i++)
            send(3'(i), 8'hA5, 8'h0F, sweep_y[i], 1);
        send(3'd5, 8'h3C, 8'h3C, 8'h00, 1);
        send(3'd4, 8'h00, 8'h00, 8'hFF, 1);
        send(3'd7, 8'h01, 8'hFF, 8'h01, 1);
        send(3'd5, 8'hF0, 8'h3C, 8'hCC, 1);
        drain();

        // backpressure window
        seen = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    send(3'(i + 1), ra, rb, ref_y(3'(i + 1), ra, rb), 0);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (!in_ready) seen = 1;
                end
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        chk("bp_in_ready_fell", seen, 1);
        drain();

        // mid-stream reset
        send(3'd1, 8'h12, 8'h34, 8'h36, 0);
        send(3'd0, 8'hFF, 8'h0F, 8'h0F, 0);
        rst = 1;
        q.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(3'd6, 8'h0F, 8'h33, 8'hC3, 1);
        drain();

        // randomized traffic with random backpressure
        rand_bp = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            rop = 3'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            send(rop, ra, rb, ref_y(rop, ra, rb), 0);
        end
        rand_bp = 0;
        @(posedge clk);
        #2;
        out_ready = 1;
        drain();

        // WIDTH=1 instance: AND 1,1 then OR 0,0
        v1_in_valid = 1;
        v1_in_op = 3'd0;
        v1_in_a = 1'b1;
        v1_in_b = 1'b1;
        @(negedge clk);
        chk("w1_in_ready", v1_in_ready, 1);
        @(posedge clk);
        #1;
        v1_in_op = 3'd1;
        v1_in_a = 1'b0;
        v1_in_b = 1'b0;
        @(posedge clk);
        #1;
        v1_in_valid = 0;
        @(negedge clk);
        chk("w1_and_valid", v1_out_valid, 1);
        chk("w1_and_y", v1_out_y, 1);
        chk("w1_and_op", v1_out_op, 0);
        chk("w1_and_flags", {v1_zero, v1_ones, v1_par}, 3'b011);
`ifdef LOGIC_POPCOUNT_EN
        chk("w1_and_popcount", v1_pc, 1);
`endif
        @(negedge clk);
        chk("w1_or_valid", v1_out_valid, 1);
        chk("w1_or_y", v1_out_y, 0);
        chk("w1_or_flags", {v1_zero, v1_ones, v1_par}, 3'b100);
        @(negedge clk);
        chk("w1_empty", v1_out_valid, 0);

        chk("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
